// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard controller bundle.
// The pipeline (master) drives the ID/EX/MEM hazard inputs; the controller (slave) drives the stall and flush controls.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [REG_AW-1:0] ex_wa_i;
    logic              ex_we_i;
    logic              ex_ld_i;
    logic [REG_AW-1:0] mem_wa_i;
    logic              mem_we_i;
    logic              mem_ld_i;
    logic              ex_br_taken_i;
    logic              stall_from_ld_2clk_o;
    logic              stall_from_ld_1clk_o;
    logic              flush_o;
    logic              hold_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_wa_i, ex_we_i, ex_ld_i,
        output mem_wa_i, mem_we_i, mem_ld_i,
        output ex_br_taken_i,
        input  stall_from_ld_2clk_o, stall_from_ld_1clk_o,
        input  flush_o, hold_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_wa_i, ex_we_i, ex_ld_i,
        input  mem_wa_i, mem_we_i, mem_ld_i,
        input  ex_br_taken_i,
        output stall_from_ld_2clk_o, stall_from_ld_1clk_o,
        output flush_o, hold_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the decode->execute boundary.
// Define HAZARD_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        WAIT1 = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] ex_wa;
    logic [REG_AW-1:0] mem_wa;
    logic              ex_hzd;
    logic              mem_hzd;
    logic              stall_2;
    logic              stall_1;
    logic              flush;

    assign rs1    = bus.id_rs1_i;
    assign rs2    = bus.id_rs2_i;
    assign ex_wa  = bus.ex_wa_i;
    assign mem_wa = bus.mem_wa_i;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign ex_hzd = bus.ex_we_i && (ex_wa != '0) &&
                    ((bus.id_rs1_used_i && (rs1 == ex_wa)) ||
                     (bus.id_rs2_used_i && (rs2 == ex_wa)));

    assign mem_hzd = bus.mem_we_i && (mem_wa != '0) &&
                     ((bus.id_rs1_used_i && (rs1 == mem_wa)) ||
                      (bus.id_rs2_used_i && (rs2 == mem_wa)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_2 = 1'b0;
        stall_1 = 1'b0;
        flush   = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The ID instruction is wrong-path on a taken branch, so flush wins
                    if (bus.ex_br_taken_i) begin
                        flush = 1'b1;
                    end else if (bus.ex_ld_i && ex_hzd) begin
                        stall_2 = 1'b1;
                        state_d = WAIT1;
                    end else if (bus.mem_ld_i && mem_hzd) begin
                        stall_1 = 1'b1;
                    end
                end
                WAIT1: begin
                    // EX holds a bubble here, so a branch cannot be resolving
                    stall_1 = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.stall_from_ld_2clk_o = stall_2;
    assign bus.stall_from_ld_1clk_o = stall_1;
    assign bus.flush_o              = flush;
    assign bus.hold_o               = (stall_2 | stall_1) & ~flush;

`ifdef HAZARD_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.hold_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic vs a bubble-count model.
// Counter expectations follow HAZARD_CTRL_PERF_EN (zero when undefined).
module tb_hazard_ctrl;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;
`ifdef HAZARD_CTRL_PERF_EN
    localparam logic [CW-1:0] CMASK = '1;
`else
    localparam logic [CW-1:0] CMASK = '0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: bubbles still owed from an earlier load-use, plus event tallies
    int owed  = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    logic [3:0] outs;
    assign outs = {bus.stall_from_ld_2clk_o, bus.stall_from_ld_1clk_o,
                   bus.flush_o, bus.hold_o};

    function automatic logic reads(logic [AW-1:0] wa, logic we);
        if (!we || wa == 0) return 1'b0;
        if (bus.id_rs1_used_i && bus.id_rs1_i == wa) return 1'b1;
        if (bus.id_rs2_used_i && bus.id_rs2_i == wa) return 1'b1;
        return 1'b0;
    endfunction

    // Expected {2clk, 1clk, flush, hold}
    function automatic logic [3:0] model_out();
        if (rst) return 4'b0000;
        if (owed > 0) return 4'b0101;
        if (bus.ex_br_taken_i) return 4'b0010;
        if (bus.ex_ld_i && reads(bus.ex_wa_i, bus.ex_we_i)) return 4'b1001;
        if (bus.mem_ld_i && reads(bus.mem_wa_i, bus.mem_we_i)) return 4'b0101;
        return 4'b0000;
    endfunction

    function automatic logic [CW-1:0] cexp(int v);
        return CW'(v) & CMASK;
    endfunction

    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        e = model_out();
        if (rst) begin
            owed   = 0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (e[3]) owed = 1;
            else if (owed > 0) owed = owed - 1;
            if (e[0] && m_scnt < CMAX) m_scnt++;
            if (e[1] && m_fcnt < CMAX) m_fcnt++;
        end
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs1_i      = '0;
        bus.id_rs2_i      = '0;
        bus.id_rs1_used_i = 1'b0;
        bus.id_rs2_used_i = 1'b0;
        bus.ex_wa_i       = '0;
        bus.ex_we_i       = 1'b0;
        bus.ex_ld_i       = 1'b0;
        bus.mem_wa_i      = '0;
        bus.mem_we_i      = 1'b0;
        bus.mem_ld_i      = 1'b0;
        bus.ex_br_taken_i = 1'b0;
    endtask

    task automatic ex_load_use(logic [AW-1:0] r);
        bus.ex_ld_i       = 1'b1;
        bus.ex_we_i       = 1'b1;
        bus.ex_wa_i       = r;
        bus.id_rs1_i      = r;
        bus.id_rs1_used_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        ex_load_use(5'd5);
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs got=%b want=0000", outs);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({outs, bus.stall_cnt_o, bus.flush_cnt_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%h want=0000/0/0",
                     outs, bus.stall_cnt_o, bus.flush_cnt_o);
        end
        tick();
        rst = 1'b0;
        clear_in();
    endtask

    task automatic test_ex_load_use();
        logic [3:0] want [3];
        want = '{4'b1001, 4'b0101, 4'b0000};
        clear_in();
        ex_load_use(5'd5);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.ex_ld_i  = 1'b0;
                bus.ex_we_i  = 1'b0;
                bus.mem_ld_i = 1'b1;
                bus.mem_we_i = 1'b1;
                bus.mem_wa_i = 5'd5;
            end
            if (c == 2) begin
                bus.mem_ld_i = 1'b0;
                bus.mem_we_i = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (outs !== want[c]) begin
                failures++;
                $display("FAIL ex_load_use cyc%0d got=%b want=%b", c, outs, want[c]);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_mem_load();
        clear_in();
        bus.mem_ld_i      = 1'b1;
        bus.mem_we_i      = 1'b1;
        bus.mem_wa_i      = 5'd7;
        bus.id_rs2_i      = 5'd7;
        bus.id_rs2_used_i = 1'b1;
        bus.ex_we_i       = 1'b1;
        bus.ex_wa_i       = 5'd3;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0101) begin
            failures++;
            $display("FAIL mem_load got=%b want=0101", outs);
        end
        tick();
        clear_in();
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL mem_load_after got=%b want=0000", outs);
        end
        tick();
    endtask

    task automatic test_no_hazard();
        clear_in();
        ex_load_use(5'd0);
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL x0_load got=%b want=0000", outs);
        end
        tick();
        ex_load_use(5'd5);
        bus.id_rs1_used_i = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL rs1_unused got=%b want=0000", outs);
        end
        tick();
        ex_load_use(5'd9);
        bus.ex_ld_i = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL alu_writer got=%b want=0000", outs);
        end
        tick();
        clear_in();
    endtask

    task automatic test_flush_priority();
        clear_in();
        ex_load_use(5'd6);
        bus.ex_br_taken_i = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0010) begin
            failures++;
            $display("FAIL flush_prio got=%b want=0010", outs);
        end
        tick();
        clear_in();
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL flush_no_bubble got=%b want=0000", outs);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_in();
        ex_load_use(5'd12);
        @(negedge clk);
        checks++;
        if (outs !== 4'b1001) begin
            failures++;
            $display("FAIL rst_mid_enter got=%b want=1001", outs);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_force got=%b want=0000", outs);
        end
        tick();
        rst = 1'b0;
        clear_in();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (outs !== 4'b0000) begin
                failures++;
                $display("FAIL rst_mid_residual cyc%0d got=%b want=0000", c, outs);
            end
            tick();
        end
    endtask

    task automatic test_perf();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
        bus.mem_ld_i      = 1'b1;
        bus.mem_we_i      = 1'b1;
        bus.mem_wa_i      = 5'd4;
        bus.id_rs1_i      = 5'd4;
        bus.id_rs1_used_i = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        clear_in();
        @(negedge clk);
        checks++;
        if (bus.stall_cnt_o !== cexp(15) || bus.flush_cnt_o !== cexp(0)) begin
            failures++;
            $display("FAIL perf_stall_sat got=%0d/%0d want=%0d/%0d",
                     bus.stall_cnt_o, bus.flush_cnt_o, cexp(15), cexp(0));
        end
        bus.ex_br_taken_i = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        clear_in();
        @(negedge clk);
        checks++;
        if (bus.stall_cnt_o !== cexp(15) || bus.flush_cnt_o !== cexp(3)) begin
            failures++;
            $display("FAIL perf_flush got=%0d/%0d want=%0d/%0d",
                     bus.stall_cnt_o, bus.flush_cnt_o, cexp(15), cexp(3));
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] e;
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(0, 99) < 3);
            bus.id_rs1_i      = AW'($urandom_range(0, 3));
            bus.id_rs2_i      = AW'($urandom_range(0, 3));
            bus.id_rs1_used_i = 1'($urandom_range(0, 1));
            bus.id_rs2_used_i = 1'($urandom_range(0, 1));
            bus.ex_wa_i       = AW'($urandom_range(0, 3));
            bus.ex_we_i       = ($urandom_range(0, 9) < 8);
            bus.ex_ld_i       = 1'($urandom_range(0, 1));
            bus.mem_wa_i      = AW'($urandom_range(0, 3));
            bus.mem_we_i      = ($urandom_range(0, 9) < 8);
            bus.mem_ld_i      = 1'($urandom_range(0, 1));
            bus.ex_br_taken_i = (owed == 0) && ($urandom_range(0, 99) < 12);
            @(negedge clk);
            e = model_out();
            checks++;
            if ({outs, bus.stall_cnt_o, bus.flush_cnt_o} !==
                {e, cexp(m_scnt), cexp(m_fcnt)}) begin
                failures++;
                $display("FAIL random cyc%0d got=%b/%0d/%0d want=%b/%0d/%0d",
                         c, outs, bus.stall_cnt_o, bus.flush_cnt_o,
                         e, cexp(m_scnt), cexp(m_fcnt));
            end
            tick();
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_ex_load_use();
        test_mem_load();
        test_no_hazard();
        test_flush_priority();
        test_reset_mid_stall();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
